mac_bias_slice: RTL and testbench
=================================

# mac_bias_slice

One depth slice of the convolution datapath. It multiplies GROUP_NB image/kernel lane pairs and accumulates them over a frame of beats, then sums the lanes with a pipelined adder tree and adds a per-frame bias. It emits one signed NUM_WIDTH result per frame. It sits between the image/kernel streaming front end and the pool/relu/rescale stages, and has no backpressure.

## Interface
- GROUP_NB, 4: lanes per beat; power of two, ≥1
- IMG_WIDTH, 16: signed image sample width
- KER_WIDTH, 16: signed kernel coefficient width
- NUM_WIDTH, IMG_WIDTH+KER_WIDTH+1: accumulator/result width (derived; not overridden)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- img  in  GROUP_NB*IMG_WIDTH  image lanes; lane i at [i*IMG_WIDTH +: IMG_WIDTH]
- ker  in  GROUP_NB*KER_WIDTH  kernel lanes; same packing
- in_val  in  1  beat valid
- in_last  in  1  last beat of frame; qualified by in_val
- bias  in  NUM_WIDTH  signed bias; sampled on the last beat
- out_data  out  NUM_WIDTH  signed frame result
- out_val  out  1  one-cycle pulse; out_data valid

## Operation
- All arithmetic is two's complement signed.
- Each lane product is img_i*ker_i, IMG_WIDTH+KER_WIDTH bits, sign-extended to NUM_WIDTH.
- Per-lane accumulator handling:
  - The first product of a frame loads the accumulator.
  - Later products of the same frame add to it.
  - Frames need no explicit clear between them.
  - A frame starts on the first valid beat after reset or after a last beat.
- Beats with in_val=0 are ignored, including gaps mid-frame.
- When the last beat's products are accumulated, all GROUP_NB accumulators are snapshotted together with the bias sampled with that beat.
- The snapshot enters a binary adder tree of log2(GROUP_NB) registered levels, then a registered bias adder.
- All sums wrap modulo 2^NUM_WIDTH; there is no saturation.
- Pipelines are fully streamed: one-beat frames may arrive every cycle, and each produces its own result.
- out_data holds its value between pulses.
- rst clears:
  - every valid/first/last tag and every accumulator;
  - out_data and out_val, to 0.
- rst mid-frame: the partial frame is discarded with no out_val, and the next beat starts a new frame.
- Frames whose last beat was already accepted are also flushed by rst.
- in_last with in_val=0 is ignored.

## Timing
- Beat sampled at edge T:
  - input register at T;
  - two product registers at T+1 and T+2;
  - accumulator updated at T+3;
  - snapshot at T+4.
- Adder tree levels follow at T+5 … T+4+log2(GROUP_NB).
- The bias register follows the tree, at T+5+log2(GROUP_NB).
- out_val is high in the cycle after edge T+5+log2(GROUP_NB), i.e. fixed latency L = 6+log2(GROUP_NB) edges from the last beat. L = 8 for GROUP_NB=4; L = 6 for GROUP_NB=1, which has no tree levels.
- Throughput is one frame result per cycle maximum.
- No ready signal: the consumer must accept every pulse.

## Structure
- Shared package holds:
  - the NUM_WIDTH derivation;
  - clog2 for tree depth;
  - the fixed latency constants: MAC stages = 4, bias stage = 1.
- One natural sub-module, mac_lane: input register, 2-stage multiply, first-aware accumulator. Instantiated GROUP_NB times.
- The tree and bias adder are generate loops in the top.

## Test plan
All scenarios use GROUP_NB=4, IMG=KER=16, NUM=33.
- **Single-beat frame:** img={1,2,3,4}, ker={5,6,7,8}, bias=10, in_last=1 → out_data=80, out_val exactly 8 cycles after the beat, one cycle wide.
- **Multi-beat with gaps:** 3 beats with all lanes img=2, ker=3, in_val low for 2 cycles between beats, bias=0 → 72.
- **Signed:** lane0 img=-1, ker=32767, other lanes 0, bias=-5 → -32772, i.e. 33'h1_FFFF_7FFC; out_val 8 cycles after the beat.
- **Wrap:** 2 beats with all lanes img=ker=-32768, bias=0 → 8·2^30=2^33 wraps to 0.
- **Back-to-back:** one-beat frames on 4 consecutive cycles, img lanes all k and ker all 1 for k=1..4, bias=0 → out_val high 4 consecutive cycles with 4, 8, 12, 16; no cross-frame leakage.
- **Reset mid-frame:**
  - 2 non-last beats of all-ones, then rst for 1 cycle, then a single last beat img=ker=1, bias=0;
  - required: no output for the discarded frame and result=4;
  - out_data and out_val read 0 after rst.

Source files
------------

// File: rtl/mac_bias_slice_pkg.sv
// Purpose: shared widths, tree-depth helper and pipeline latency constants for mac_bias_slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package mac_bias_slice_pkg;

  // Input register, two product registers, accumulator.
  localparam int MAC_STAGES  = 4;
  // Accumulator snapshot register feeding the adder tree.
  localparam int SNAP_STAGES = 1;
  // Final bias adder register.
  localparam int BIAS_STAGES = 1;

  // Ceiling log2; returns 0 for v <= 1 so a single-lane slice has no tree levels.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Product width plus one guard bit for accumulation.
  function automatic int num_width(input int iw, input int kw);
    return iw + kw + 1;
  endfunction

  // Edges from the last beat to the visible out_val pulse.
  function automatic int slice_latency(input int g);
    return MAC_STAGES + SNAP_STAGES + clog2(g) + BIAS_STAGES;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// Purpose: one lane: input register, 2-stage signed multiply, first-aware frame accumulator.
// Latency: accumulator reflects a beat 4 edges after it is sampled; acc_last pulses with it.
// Backpressure: none; every valid beat is consumed.
// Ports: img/ker lane samples, in_val/in_last beat tags, acc running sum, acc_last frame done.
module mac_lane
  import mac_bias_slice_pkg::*;
#(
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  localparam int NUM_WIDTH  = num_width(IMG_WIDTH, KER_WIDTH),
  localparam int PROD_WIDTH = IMG_WIDTH + KER_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IMG_WIDTH-1:0] img,
  input  logic [KER_WIDTH-1:0] ker,
  input  logic                 in_val,
  input  logic                 in_last,
  output logic [NUM_WIDTH-1:0] acc,
  output logic                 acc_last
);

  logic signed [IMG_WIDTH-1:0]  img_r;
  logic signed [KER_WIDTH-1:0]  ker_r;
  logic signed [PROD_WIDTH-1:0] prod1;
  logic signed [PROD_WIDTH-1:0] prod2;
  logic [2:0]                   vld;   // beat valid tag per stage
  logic [2:0]                   lst;   // last tag per stage, already qualified by valid
  logic                         first; // next valid product starts a new frame
  logic [NUM_WIDTH-1:0]         prod_ext;

  assign prod_ext = {{(NUM_WIDTH - PROD_WIDTH){prod2[PROD_WIDTH-1]}}, prod2};

  always_ff @(posedge clk) begin
    if (rst) begin
      img_r    <= '0;
      ker_r    <= '0;
      prod1    <= '0;
      prod2    <= '0;
      vld      <= '0;
      lst      <= '0;
      first    <= 1'b1;
      acc      <= '0;
      acc_last <= 1'b0;
    end else begin
      img_r    <= img;
      ker_r    <= ker;
      vld      <= {vld[1:0], in_val};
      lst      <= {lst[1:0], in_val & in_last};
      // Size casts sign-extend the signed operands so the product is full width.
      prod1    <= PROD_WIDTH'(img_r) * PROD_WIDTH'(ker_r);
      prod2    <= prod1;
      // Loading on the first product removes any need to clear between frames.
      if (vld[2]) begin
        acc   <= first ? prod_ext : acc + prod_ext;
        first <= lst[2];
      end
      acc_last <= lst[2];
    end
  end

endmodule

// File: rtl/mac_bias_slice.sv
// Purpose: GROUP_NB-lane MAC over a frame, pipelined adder tree, per-frame bias add.
// Latency: out_val pulses 6+log2(GROUP_NB) edges after the last beat is sampled.
// Backpressure: none; one result per cycle maximum, consumer must take every pulse.
// Ports: img/ker packed lanes (lane i at [i*W +: W]), in_val/in_last beat tags,
//        bias sampled with the last beat, out_data/out_val frame result.
module mac_bias_slice
  import mac_bias_slice_pkg::*;
#(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  localparam int NUM_WIDTH = num_width(IMG_WIDTH, KER_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GROUP_NB*IMG_WIDTH-1:0] img,
  input  logic [GROUP_NB*KER_WIDTH-1:0] ker,
  input  logic                          in_val,
  input  logic                          in_last,
  input  logic [NUM_WIDTH-1:0]          bias,
  output logic [NUM_WIDTH-1:0]          out_data,
  output logic                          out_val
);

  localparam int DEPTH = clog2(GROUP_NB);

  logic [NUM_WIDTH-1:0] lane_acc [GROUP_NB];
  logic [GROUP_NB-1:0]  lane_last;
  logic                 snap_en;

  // Heap-indexed tree: leaves at GROUP_NB..2*GROUP_NB-1, root at 1.
  // Every node is a register, so each tree level is one pipeline stage.
  logic [NUM_WIDTH-1:0] tree [1:2*GROUP_NB-1];

  logic [NUM_WIDTH-1:0] bias_mac  [MAC_STAGES];
  logic [NUM_WIDTH-1:0] bias_tree [DEPTH+1];
  logic [DEPTH:0]       vld_tree;

  genvar gi;
  generate
    for (gi = 0; gi < GROUP_NB; gi++) begin : g_lane
      mac_lane #(
        .IMG_WIDTH (IMG_WIDTH),
        .KER_WIDTH (KER_WIDTH)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .img      (img[gi*IMG_WIDTH +: IMG_WIDTH]),
        .ker      (ker[gi*KER_WIDTH +: KER_WIDTH]),
        .in_val   (in_val),
        .in_last  (in_last),
        .acc      (lane_acc[gi]),
        .acc_last (lane_last[gi])
      );
    end
  endgenerate

  // All lanes see identical tags, so the AND is just lane 0's frame-done.
  assign snap_en = &lane_last;

  // Bias rides alongside the MAC stages so it meets its own frame at the snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MAC_STAGES; k++) bias_mac[k] <= '0;
    end else begin
      bias_mac[0] <= bias;
      for (int k = 1; k < MAC_STAGES; k++) bias_mac[k] <= bias_mac[k-1];
    end
  end

  generate
    for (gi = 0; gi < GROUP_NB; gi++) begin : g_leaf
      always_ff @(posedge clk) begin
        if (rst) tree[GROUP_NB+gi] <= '0;
        else if (snap_en) tree[GROUP_NB+gi] <= lane_acc[gi];
      end
    end
    for (gi = 1; gi < GROUP_NB; gi++) begin : g_node
      always_ff @(posedge clk) begin
        if (rst) tree[gi] <= '0;
        else tree[gi] <= tree[2*gi] + tree[2*gi+1];
      end
    end
  endgenerate

  // Valid tag and bias delayed in step with the tree levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_tree <= '0;
      for (int k = 0; k <= DEPTH; k++) bias_tree[k] <= '0;
    end else begin
      vld_tree[0]  <= snap_en;
      bias_tree[0] <= bias_mac[MAC_STAGES-1];
      for (int k = 1; k <= DEPTH; k++) begin
        vld_tree[k]  <= vld_tree[k-1];
        bias_tree[k] <= bias_tree[k-1];
      end
    end
  end

  // Output register doubles as the bias adder; data holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_val  <= 1'b0;
    end else begin
      out_val <= vld_tree[DEPTH];
      if (vld_tree[DEPTH]) out_data <= tree[1] + bias_tree[DEPTH];
    end
  end

endmodule

// File: tb/tb_mac_bias_slice.sv
// Purpose: self-checking bench for mac_bias_slice (GROUP_NB=4, 16x16, 33-bit result).
// Latency: results expected 8 cycles after the last beat.
// Backpressure: none; every pulse is checked against the frame model.
module tb_mac_bias_slice;
  import mac_bias_slice_pkg::*;

  localparam int G   = 4;
  localparam int NW  = 33;
  localparam int LAT = slice_latency(G);

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   img, ker;
  logic          in_val, in_last;
  logic [NW-1:0] bias, out_data;
  logic          out_val;

  always #5 clk = ~clk;

  mac_bias_slice #(.GROUP_NB(G), .IMG_WIDTH(16), .KER_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .img      (img),
    .ker      (ker),
    .in_val   (in_val),
    .in_last  (in_last),
    .bias     (bias),
    .out_data (out_data),
    .out_val  (out_val)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  typedef struct {
    int            due;
    logic [NW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  logic [NW-1:0] seen_q[$];
  logic [NW-1:0] last_seen;
  int            last_pulse_cyc;
  longint        frame_sum = 0;
  int            beat_cyc;

  task automatic check(input string name, input logic [NW-1:0] got, input logic [NW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Each cycle: a pulse is required exactly when a frame result is due, else out_val low.
  always @(negedge clk) begin
    if (checking) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (out_val !== 1'b1 || out_data !== exp_q[0].val) begin
          errors++;
          $display("FAIL frame_result cyc=%0d: got val=%b data=%0h, want val=1 data=%0h",
                   cyc, out_val, out_data, exp_q[0].val);
        end
        void'(exp_q.pop_front());
      end else if (out_val !== 1'b0) begin
        errors++;
        $display("FAIL spurious_pulse cyc=%0d: got val=%b data=%0h, want val=0", cyc, out_val, out_data);
      end
      if (out_val === 1'b1) begin
        last_seen      = out_data;
        last_pulse_cyc = cyc;
        seen_q.push_back(out_data);
      end
    end
  end

  function automatic logic [63:0] pack4(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Drive one valid beat and fold it into the frame model.
  task automatic beat(input logic [63:0] iv, input logic [63:0] kv, input logic last, input logic [NW-1:0] b);
    @(posedge clk);
    #1;
    img = iv; ker = kv; in_val = 1'b1; in_last = last; bias = b;
    beat_cyc = cyc;
    for (int i = 0; i < G; i++)
      frame_sum += longint'($signed(iv[16*i +: 16])) * longint'($signed(kv[16*i +: 16]));
    if (last) begin
      exp_q.push_back('{due: cyc + LAT, val: NW'(frame_sum + longint'($signed(b)))});
      frame_sum = 0;
    end
  endtask

  // Invalid cycles carry junk data (and optionally in_last) that must be ignored.
  task automatic idle(input int n, input logic last);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_val = 1'b0; in_last = last; bias = 33'h1_2345_6789;
      img = 64'hDEAD_BEEF_0BAD_F00D; ker = 64'h7FFF_8000_1234_ABCD;
    end
  endtask

  task automatic drain();
    idle(1, 1'b0);
    repeat (LAT + 3) @(negedge clk);
    #1;
    check("drain_empty", NW'(exp_q.size()), '0);
  endtask

  initial begin
    int b0;
    rst = 1'b1; in_val = 1'b0; in_last = 1'b0; img = '0; ker = '0; bias = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_val", NW'(out_val), '0);
    check("reset_out_data", out_data, '0);
    checking = 1'b1;

    // Single-beat frame: 5+12+21+32+10 = 80.
    beat(pack4(16'd1, 16'd2, 16'd3, 16'd4), pack4(16'd5, 16'd6, 16'd7, 16'd8), 1'b1, 33'd10);
    b0 = beat_cyc;
    drain();
    check("single_result", last_seen, 33'd80);
    check("single_latency", NW'(last_pulse_cyc - b0), 33'd8);
    check("single_hold", out_data, 33'd80);

    // Multi-beat with gaps: 3 beats * 4 lanes * 6 = 72; only the last beat's bias counts.
    beat({4{16'd2}}, {4{16'd3}}, 1'b0, 33'd999);
    idle(2, 1'b0);
    beat({4{16'd2}}, {4{16'd3}}, 1'b0, 33'd999);
    idle(2, 1'b1);
    beat({4{16'd2}}, {4{16'd3}}, 1'b1, 33'd0);
    drain();
    check("multi_gap_result", last_seen, 33'd72);

    // Signed: -1*32767 - 5 = -32772.
    beat(pack4(16'hFFFF, 16'd0, 16'd0, 16'd0), pack4(16'd32767, 16'd0, 16'd0, 16'd0), 1'b1, -33'sd5);
    b0 = beat_cyc;
    drain();
    check("signed_result", last_seen, 33'h1_FFFF_7FFC);
    check("signed_latency", NW'(last_pulse_cyc - b0), 33'd8);

    // Wrap: 8 * 2^30 = 2^33 wraps to 0.
    beat({4{16'h8000}}, {4{16'h8000}}, 1'b0, 33'd0);
    beat({4{16'h8000}}, {4{16'h8000}}, 1'b1, 33'd0);
    drain();
    check("wrap_result", last_seen, 33'd0);

    // Back-to-back one-beat frames.
    seen_q.delete();
    for (int k = 1; k <= 4; k++) beat({4{16'(k)}}, {4{16'd1}}, 1'b1, 33'd0);
    drain();
    check("b2b_count", NW'(seen_q.size()), 33'd4);
    for (int k = 0; k < 4; k++)
      if (k < seen_q.size()) check("b2b_result", seen_q[k], NW'(4 * (k + 1)));

    // Reset mid-frame: partial frame discarded, outputs cleared, next beat starts fresh.
    seen_q.delete();
    beat({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b0, 33'd0);
    beat({4{16'hFFFF}}, {4{16'hFFFF}}, 1'b0, 33'd0);
    @(posedge clk);
    #1;
    in_val = 1'b0; in_last = 1'b0; rst = 1'b1;
    frame_sum = 0;
    while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_out_val", NW'(out_val), '0);
    check("rst_mid_out_data", out_data, '0);
    beat({4{16'd1}}, {4{16'd1}}, 1'b1, 33'd0);
    drain();
    check("rst_mid_count", NW'(seen_q.size()), 33'd1);
    check("rst_mid_result", last_seen, 33'd4);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
